// File: rtl/sipo_rx_pkg.sv
// Shared types and helpers for the CE-strobed serial-in/parallel-out receiver.
package sipo_rx_pkg;

  localparam int SIPO_N_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

  // Bits needed to hold values 0..v-1; the bit counter uses clog2(N+1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// N-bit CE-gated left shifter, serial in at the LSB, synchronous clear.
// Receive-side partner of the PISO shifter.
//
// q_next is the word as it will stand after the next enabled edge, i.e. the
// stored bits with the live serial bit appended. The receiver captures its
// completed word from q_next on the same edge the final bit is sampled, so the
// top stored bit would be shifted out before anyone looks at it; only N-1
// bits are kept as state.
module sipo_shift_reg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         si,
  output logic [N-1:0] q_next
);

  generate
    if (N == 1) begin : g_one
      // A one-bit word is just the live serial bit; nothing to store.
      assign q_next = si;
    end else begin : g_multi
      logic [N-2:0] sr;

      assign q_next = {sr, si};

      // Shift on each enabled strobe; clear wins.
      always_ff @(posedge clk) begin
        if (clr)     sr <= '0;
        else if (en) sr <= q_next[N-2:0];
      end
    end
  endgenerate

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out word receiver. MSB-first bits arrive one per CE
// strobe; SYNC (qualified by CE) marks the first bit of a word. A completed
// word is held on PO with a one-cycle VALID pulse; a SYNC arriving mid-word
// discards the partial word, pulses ERR and restarts.
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int N = SIPO_N_DEFAULT
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CE,
  input  logic         SI,
  input  logic         SYNC,
  output logic [N-1:0] PO,
  output logic         VALID,
  output logic         BUSY,
  output logic         ERR
);

  localparam int CW = clog2(N + 1);

  sipo_state_t   state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [N-1:0]  sr_next;
  logic          shift_en;

  assign cnt_inc = cnt + CW'(1);

  // SI is only taken when it belongs to a word: a framed start, or any strobe
  // while a word is in progress. Unframed strobes in IDLE leave SR alone.
  assign shift_en = CE & (SYNC | (state == SHIFT));

  sipo_shift_reg #(.N(N)) u_sr (
    .clk    (CLK),
    .clr    (RESET),
    .en     (shift_en),
    .si     (SI),
    .q_next (sr_next)
  );

  // Framing FSM, bit counter and registered outputs. VALID and ERR default
  // low every cycle so they can only ever be single-cycle pulses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      PO    <= '0;
      VALID <= 1'b0;
      BUSY  <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      VALID <= 1'b0;
      ERR   <= 1'b0;
      if (CE) begin
        unique case (state)
          IDLE: begin
            if (SYNC) begin
              if (N == 1) begin
                // Single-bit word completes on its start strobe.
                PO    <= sr_next;
                VALID <= 1'b1;
                cnt   <= '0;
              end else begin
                state <= SHIFT;
                BUSY  <= 1'b1;
                cnt   <= CW'(1);
              end
            end
          end
          SHIFT: begin
            if (SYNC) begin
              // Resync: drop the partial word, this bit starts a fresh one.
              ERR <= 1'b1;
              if (N == 1) begin
                PO    <= sr_next;
                VALID <= 1'b1;
                cnt   <= '0;
                state <= IDLE;
                BUSY  <= 1'b0;
              end else begin
                cnt <= CW'(1);
              end
            end else if (cnt_inc == CW'(N)) begin
              PO    <= sr_next;
              VALID <= 1'b1;
              cnt   <= '0;
              state <= IDLE;
              BUSY  <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            BUSY  <= 1'b0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: an N=4 and an N=1 instance share one stimulus stream.
// A word-level reference model (bit accumulator + framing flag) predicts
// PO/VALID/BUSY/ERR for every cycle; directed test-plan scenarios run first,
// then randomized CE/SYNC/SI/RESET traffic.
module tb_sipo_rx;

  logic       CLK = 1'b0;
  logic       RESET, CE, SI, SYNC;
  logic [3:0] po4;
  logic       v4, b4, e4;
  logic [0:0] po1;
  logic       v1, b1, e1;

  always #5 CLK = ~CLK;

  sipo_rx #(.N(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .CE(CE), .SI(SI), .SYNC(SYNC),
    .PO(po4), .VALID(v4), .BUSY(b4), .ERR(e4)
  );

  sipo_rx #(.N(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .CE(CE), .SI(SI), .SYNC(SYNC),
    .PO(po1), .VALID(v1), .BUSY(b1), .ERR(e1)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state per instance.
  int          cnt4 = 0, cnt1 = 0;
  bit          act4 = 0, act1 = 0;
  logic [31:0] acc4 = 0, acc1 = 0, xpo4 = 0, xpo1 = 0;
  bit          xv4 = 0, xe4 = 0, xb4 = 0, xv1 = 0, xe1 = 0, xb1 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Word-level behaviour: a word is a list of n bits, first bit most
  // significant, framed by a SYNC strobe; a new SYNC while a word is open
  // is an error that restarts framing.
  task automatic mdl(input int n, input bit rst, input bit ce, input bit sy, input bit si,
                     inout int cnt, inout bit act, inout logic [31:0] acc,
                     inout logic [31:0] po, inout bit v, inout bit e, inout bit b);
    v = 0;
    e = 0;
    if (rst) begin
      cnt = 0; act = 0; acc = 0; po = 0; b = 0;
      return;
    end
    if (ce && sy) begin
      e   = act;
      act = 1;
      acc = 32'(si);
      cnt = 1;
    end else if (ce && act) begin
      acc = acc * 2 + 32'(si);
      cnt++;
    end
    if (act && cnt == n) begin
      po  = acc;
      v   = 1;
      act = 0;
      cnt = 0;
    end
    b = act;
  endtask

  // One clock: apply inputs, advance the model on the edge, compare 1 time unit later.
  task automatic step(input bit rst, input bit ce, input bit sy, input bit si);
    RESET = rst; CE = ce; SYNC = sy; SI = si;
    @(posedge CLK);
    mdl(4, rst, ce, sy, si, cnt4, act4, acc4, xpo4, xv4, xe4, xb4);
    mdl(1, rst, ce, sy, si, cnt1, act1, acc1, xpo1, xv1, xe1, xb1);
    #1;
    chk("po4",    32'(po4), xpo4);
    chk("valid4", 32'(v4),  32'(xv4));
    chk("busy4",  32'(b4),  32'(xb4));
    chk("err4",   32'(e4),  32'(xe4));
    chk("po1",    32'(po1), xpo1);
    chk("valid1", 32'(v1),  32'(xv1));
    chk("busy1",  32'(b1),  32'(xb1));
    chk("err1",   32'(e1),  32'(xe1));
  endtask

  // Full-rate 4-bit word, SYNC on its first bit.
  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) step(0, 1, i == 0, w[3 - i]);
  endtask

  initial begin
    RESET = 1; CE = 0; SI = 0; SYNC = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_po4", 32'(po4), 32'h0);
    chk("rst_busy4", 32'(b4), 32'h0);

    // 4'hB with three idle cycles between strobes.
    step(0, 1, 1, 1);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    chk("gap_v_early", 32'(v4), 32'h0);
    step(0, 1, 0, 1);
    chk("gap_valid", 32'(v4), 32'h1);
    chk("gap_po", 32'(po4), 32'hB);
    step(0, 0, 0, 0);
    chk("gap_valid_once", 32'(v4), 32'h0);
    chk("gap_busy_low", 32'(b4), 32'h0);

    // Back-to-back at full rate.
    send_word(4'hB);
    chk("b2b_v1", 32'(v4), 32'h1);
    chk("b2b_po1", 32'(po4), 32'hB);
    send_word(4'h4);
    chk("b2b_v2", 32'(v4), 32'h1);
    chk("b2b_po2", 32'(po4), 32'h4);
    chk("b2b_noerr", 32'(e4), 32'h0);

    // Resync after two bits.
    step(0, 1, 1, 1);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    chk("resync_err", 32'(e4), 32'h1);
    step(0, 1, 0, 1);
    chk("resync_err_pulse", 32'(e4), 32'h0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    chk("resync_po", 32'(po4), 32'h6);
    chk("resync_valid", 32'(v4), 32'h1);

    // Unframed strobes and SYNC without CE do nothing.
    repeat (3) step(0, 1, 0, 1);
    repeat (2) step(0, 0, 1, 1);
    chk("frame_busy", 32'(b4), 32'h0);
    chk("frame_po", 32'(po4), 32'h6);

    // Reset mid-word, then a clean word.
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    step(1, 0, 0, 0);
    chk("midrst_po", 32'(po4), 32'h0);
    chk("midrst_busy", 32'(b4), 32'h0);
    step(0, 0, 0, 0);
    send_word(4'hF);
    chk("post_rst_po", 32'(po4), 32'hF);

    // Single-bit instance completes on the start strobe.
    step(0, 1, 1, 0);
    step(0, 1, 1, 1);
    chk("n1_po", 32'(po1), 32'h1);
    chk("n1_valid", 32'(v1), 32'h1);
    chk("n1_busy", 32'(b1), 32'h0);

    // Randomized traffic.
    repeat (3000)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 15, 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
